// File: rtl/stream_arb_mux.sv
// Registered N:1 stream multiplexer with built-in arbitration.
// Each input channel and the output use a valid/ready handshake.
// The output register adds one cycle of latency and still accepts
// a new word every cycle.
// Arbitration is selected by ARB_MODE: round-robin (0) or fixed priority (1).
module stream_arb_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int ARB_MODE = 0,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_sel
);

    logic [SEL_W-1:0]    ptr;
    logic [SEL_W-1:0]    grant_idx;
    logic                found;
    logic [SEL_W:0]      cand;
    logic [CHANNELS-1:0] grant;
    logic                load;
    logic                xfer;

    assign load = !out_valid || out_ready;

    // Search from ptr upward with wrap; the first valid channel wins.
    // In fixed-priority mode ptr stays 0, so the same search returns the
    // lowest valid index.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        grant     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand = {1'b0, ptr} + (SEL_W+1)'(k);
            if (cand >= (SEL_W+1)'(CHANNELS)) begin
                cand = cand - (SEL_W+1)'(CHANNELS);
            end
            if (!found && in_valid[cand[SEL_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[SEL_W-1:0];
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Ready is granted only when the output register can take a word.
    // It is held at zero for the whole of reset.
    assign in_ready = (load && !rst) ? grant : '0;
    assign xfer     = |in_ready;

    // Output register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (xfer) begin
                out_data  <= in_data[grant_idx*WIDTH +: WIDTH];
                out_sel   <= grant_idx;
                out_valid <= 1'b1;
                if (ARB_MODE == 0) begin
                    if (grant_idx == SEL_W'(CHANNELS-1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= grant_idx + 1'b1;
                    end
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench for stream_arb_mux: a round-robin instance and a
// fixed-priority instance share the clock and reset.
module tb_stream_arb_mux;

    logic        clk;
    logic        rst;

    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_sel;

    logic [31:0] fp_in_data;
    logic [3:0]  fp_in_valid;
    logic [3:0]  fp_in_ready;
    logic [7:0]  fp_out_data;
    logic        fp_out_valid;
    logic        fp_out_ready;
    logic [1:0]  fp_out_sel;

    int n_checks;
    int n_fail;

    stream_arb_mux #(.WIDTH(8), .CHANNELS(4), .ARB_MODE(0)) dut_rr (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sel(out_sel)
    );

    stream_arb_mux #(.WIDTH(8), .CHANNELS(4), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst(rst),
        .in_data(fp_in_data), .in_valid(fp_in_valid), .in_ready(fp_in_ready),
        .out_data(fp_out_data), .out_valid(fp_out_valid), .out_ready(fp_out_ready),
        .out_sel(fp_out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        in_data   = 32'hA3A2A1A0;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        rst       = 1'b1;
        tick();
        tick();
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_out got valid=%b data=%h sel=%0d exp 0/00/0",
                     out_valid, out_data, out_sel);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin
            n_fail++; $display("FAIL reset_first_grant got=%b exp=0001", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'hA0) begin
            n_fail++;
            $display("FAIL reset_first_word got valid=%b sel=%0d data=%h exp 1/0/a0",
                     out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_rr_all_valid();
        in_data   = 32'hA3A2A1A0;
        in_valid  = 4'h0;
        out_ready = 1'b1;
        do_reset();
        in_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== 2'(i % 4) || out_data !== 8'(8'hA0 + i % 4)) begin
                n_fail++;
                $display("FAIL rr_all step=%0d got valid=%b sel=%0d data=%h exp 1/%0d/%h",
                         i, out_valid, out_sel, out_data, i % 4, 8'(8'hA0 + i % 4));
            end
        end
    endtask

    task automatic test_rr_single_then_wrap();
        in_data   = 32'hA3A2A1A0;
        in_valid  = 4'h0;
        out_ready = 1'b1;
        do_reset();
        in_valid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 4'b0100) begin
                n_fail++; $display("FAIL rr_single_ready step=%0d got=%b exp=0100", i, in_ready);
            end
            tick();
            n_checks++;
            if (out_sel !== 2'd2 || out_data !== 8'hA2 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_single step=%0d got sel=%0d data=%h exp 2/a2", i, out_sel, out_data);
            end
        end
        in_valid = 4'b1001;
        tick();
        n_checks++;
        if (out_sel !== 2'd3 || out_data !== 8'hA3) begin
            n_fail++; $display("FAIL rr_after_ch2 got sel=%0d data=%h exp 3/a3", out_sel, out_data);
        end
        tick();
        n_checks++;
        if (out_sel !== 2'd0 || out_data !== 8'hA0) begin
            n_fail++; $display("FAIL rr_wrap got sel=%0d data=%h exp 0/a0", out_sel, out_data);
        end
    endtask

    task automatic test_stall();
        in_data   = 32'hA3A2A1A0;
        in_valid  = 4'h0;
        out_ready = 1'b1;
        do_reset();
        in_valid = 4'hF;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 4'b0000) begin
                n_fail++; $display("FAIL stall_ready step=%0d got=%b exp=0000", i, in_ready);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'hA0) begin
                n_fail++;
                $display("FAIL stall_hold step=%0d got valid=%b sel=%0d data=%h exp 1/0/a0",
                         i, out_valid, out_sel, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0010) begin
            n_fail++; $display("FAIL stall_release_ready got=%b exp=0010", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'hA1) begin
            n_fail++;
            $display("FAIL stall_drain_load got valid=%b sel=%0d data=%h exp 1/1/a1",
                     out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_fixed_priority();
        fp_in_data   = 32'hB3B2B1B0;
        fp_in_valid  = 4'h0;
        fp_out_ready = 1'b1;
        do_reset();
        fp_in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (fp_in_ready !== 4'b0010) begin
                n_fail++; $display("FAIL fp_ready step=%0d got=%b exp=0010", i, fp_in_ready);
            end
            tick();
            n_checks++;
            if (fp_out_sel !== 2'd1 || fp_out_data !== 8'hB1 || fp_out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL fp_ch1 step=%0d got sel=%0d data=%h exp 1/b1", i, fp_out_sel, fp_out_data);
            end
        end
        fp_in_valid = 4'b1000;
        #1;
        n_checks++;
        if (fp_in_ready !== 4'b1000) begin
            n_fail++; $display("FAIL fp_ch3_ready got=%b exp=1000", fp_in_ready);
        end
        tick();
        n_checks++;
        if (fp_out_sel !== 2'd3 || fp_out_data !== 8'hB3) begin
            n_fail++; $display("FAIL fp_ch3 got sel=%0d data=%h exp 3/b3", fp_out_sel, fp_out_data);
        end
        fp_in_valid = 4'h0;
        tick();
        n_checks++;
        if (fp_out_valid !== 1'b0 || fp_out_sel !== 2'd3 || fp_out_data !== 8'hB3) begin
            n_fail++;
            $display("FAIL fp_idle got valid=%b sel=%0d data=%h exp 0/3/b3",
                     fp_out_valid, fp_out_sel, fp_out_data);
        end
    endtask

    task automatic test_mid_reset();
        in_data   = 32'hA3A2A1A0;
        in_valid  = 4'h0;
        out_ready = 1'b1;
        do_reset();
        in_valid = 4'hF;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd1) begin
            n_fail++; $display("FAIL mid_pre got valid=%b sel=%0d exp 1/1", out_valid, out_sel);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_async got valid=%b data=%h ready=%b exp 0/00/0000",
                     out_valid, out_data, in_ready);
        end
        tick();
        rst      = 1'b0;
        in_valid = 4'b0101;
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin
            n_fail++; $display("FAIL mid_ready got=%b exp=0001", in_ready);
        end
        tick();
        n_checks++;
        if (out_sel !== 2'd0 || out_data !== 8'hA0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_grant got sel=%0d data=%h exp 0/a0", out_sel, out_data);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        in_data      = '0;
        in_valid     = '0;
        out_ready    = 1'b0;
        fp_in_data   = '0;
        fp_in_valid  = '0;
        fp_out_ready = 1'b0;
        #1;
        test_reset();
        test_rr_all_valid();
        test_rr_single_then_wrap();
        test_stall();
        test_fixed_priority();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
